// File: rtl/vram_fb_if.sv
// Producer/display-side bundle of the double-buffered framebuffer.
// The producer drives scan/write/swap; the framebuffer returns scan-out pixels and buffer status.
interface vram_fb_if #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 3
);
    logic              scan_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              swap_req;
    logic [PIX_W-1:0]  pixel_val;
    logic              pixel_valid;
    logic [ADDR_W-1:0] pixel_addr;
    logic              frame_start;
    logic              front_sel;
    logic              swap_pending;

    modport master (
        output scan_en, wr_en, wr_addr, wr_data, swap_req,
        input  pixel_val, pixel_valid, pixel_addr, frame_start, front_sel, swap_pending
    );

    modport slave (
        input  scan_en, wr_en, wr_addr, wr_data, swap_req,
        output pixel_val, pixel_valid, pixel_addr, frame_start, front_sel, swap_pending
    );
endinterface

// File: rtl/vram_fb.sv
// Double-buffered framebuffer: scan counter streams the front frame through a 2-stage
// read pipeline while the write port fills the back frame; swaps happen only on frame wrap.
module vram_fb #(
    parameter int H_RES    = 128,
    parameter int V_RES    = 96,
    parameter int CHANNELS = 3,
    parameter int BPC      = 1,
    parameter int ADDR_W   = 14
) (
    input  logic      clk,
    input  logic      reset,
    vram_fb_if.slave  bus
);
    localparam int N      = H_RES * V_RES;
    localparam int PIX_W  = CHANNELS * BPC;
    localparam int DEPTH  = 2 ** (ADDR_W + 1);
    localparam int STAGES = 2;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_LIM = (ADDR_W + 1)'(N);

    logic [PIX_W-1:0]  mem [DEPTH];
    logic [PIX_W-1:0]  rd_data;
    logic [ADDR_W-1:0] scan_cnt;
    logic [ADDR_W-1:0] s1_addr;
    logic [STAGES:1]   vld_pipe;
    logic [PIX_W-1:0]  pix_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fs_q;
    logic              front_q;
    logic              pend_q;
    logic              wr_ok;
    logic              wrap;
    logic              take;

    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < N_LIM);
    assign wrap  = bus.scan_en && (scan_cnt == LAST);
    assign take  = wrap && (pend_q || bus.swap_req);

    // Block RAM: reads hit the front half, writes the back half, so they never collide.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[{~front_q, bus.wr_addr}] <= bus.wr_data;
        if (bus.scan_en)
            rd_data <= mem[{front_q, scan_cnt}];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            s1_addr  <= '0;
            vld_pipe <= '0;
            pix_q    <= '0;
            addr_q   <= '0;
            fs_q     <= 1'b0;
            front_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            if (bus.scan_en) begin
                scan_cnt <= (scan_cnt == LAST) ? '0 : scan_cnt + 1'b1;
                s1_addr  <= scan_cnt;
            end
            if (take)
                front_q <= ~front_q;
            // A request arriving on the wrap edge itself is consumed without ever showing as pending.
            pend_q   <= take ? 1'b0 : (pend_q | bus.swap_req);
            vld_pipe <= {vld_pipe[1], bus.scan_en};
            if (vld_pipe[1]) begin
                pix_q  <= rd_data;
                addr_q <= s1_addr;
            end
            fs_q <= vld_pipe[1] && (s1_addr == '0);
        end
    end

    assign bus.pixel_val    = pix_q;
    assign bus.pixel_valid  = vld_pipe[STAGES];
    assign bus.pixel_addr   = addr_q;
    assign bus.frame_start  = fs_q;
    assign bus.front_sel    = front_q;
    assign bus.swap_pending = pend_q;
endmodule
